// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU round-robin scheduler.
package alu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic OP_ADD   = 1'b0;
   localparam logic OP_SUB   = 1'b1;
   localparam int   RESULT_W = 8;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    ptr,
   output logic               any_valid,
   output logic [ID_W-1:0]    win_id
);

   int idx;

   // Walk offsets from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      any_valid = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (req_valid[idx]) begin
            any_valid = 1'b1;
            win_id    = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/alu_sched.sv
// Shares one registered add/sub ALU between NUM_REQ requesters, one operation at a time.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     req_op,
   input  logic [4*NUM_REQ-1:0]   req_a,
   input  logic [4*NUM_REQ-1:0]   req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [RESULT_W-1:0]    rsp_y,
   output logic                   busy,
   output logic                   alu_en,
   output logic                   alu_op,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   input  logic [RESULT_W-1:0]    alu_y
);

   state_t                state;
   logic [ID_W-1:0]       ptr;
   logic [ID_W-1:0]       win_id;
   logic                  any_valid;
   logic                  grant;
   logic [ID_W-1:0]       lat_id;
   logic                  lat_op;
   logic [3:0]            lat_a;
   logic [3:0]            lat_b;
   logic [ID_W-1:0]       id_q;
   logic [RESULT_W-1:0]   y_q;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req_valid (req_valid),
      .ptr       (ptr),
      .any_valid (any_valid),
      .win_id    (win_id)
   );

   // Handshakes: a request transfers on req_valid[i] & req_ready[i] at a rising
   // edge, a response on rsp_valid & rsp_ready; both sides hold their payload
   // stable while valid is high and ready is low.
   assign grant = (state == IDLE) && any_valid && !reset;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[win_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= '0;
         lat_id <= '0;
         lat_op <= 1'b0;
         lat_a  <= '0;
         lat_b  <= '0;
         id_q   <= '0;
         y_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  lat_id <= win_id;
                  lat_op <= req_op[win_id];
                  lat_a  <= req_a[{win_id, 2'b00} +: 4];
                  lat_b  <= req_b[{win_id, 2'b00} +: 4];
                  state  <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               // alu_y was updated by the ISSUE edge; advance past the winner.
               y_q   <= alu_y;
               id_q  <= lat_id;
               ptr   <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + ID_W'(1);
               state <= RESP;
            end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Operand lines keep the last latched values outside ISSUE to limit toggling.
   assign alu_en    = (state == ISSUE);
   assign alu_op    = lat_op;
   assign alu_a     = lat_a;
   assign alu_b     = lat_b;
   assign rsp_valid = (state == RESP);
   assign rsp_id    = id_q;
   assign rsp_y     = y_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural ALU and a response scoreboard.
module tb_alu_sched;
   import alu_sched_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int EW      = ID_W + RESULT_W;

   logic                  clk;
   logic                  reset;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_op;
   logic [4*NUM_REQ-1:0]  req_a;
   logic [4*NUM_REQ-1:0]  req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [RESULT_W-1:0]   rsp_y;
   logic                  busy;
   logic                  alu_en;
   logic                  alu_op;
   logic [3:0]            alu_a;
   logic [3:0]            alu_b;
   logic [RESULT_W-1:0]   alu_y;

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   alu_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .busy      (busy),
      .alu_en    (alu_en),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_y     (alu_y)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural ALU: 8-bit add/sub, registered, one-cycle latency
   initial alu_y = '0;
   always @(posedge clk)
      if (alu_en)
         alu_y <= (alu_op == OP_SUB) ? ({4'h0, alu_a} - {4'h0, alu_b})
                                     : ({4'h0, alu_a} + {4'h0, alu_b});

   // requester protocol: hold valid and operands until accepted
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
      assert property (@(posedge clk) disable iff (reset)
         (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_op[i]) && $stable(req_a[4*i +: 4]) && $stable(req_b[4*i +: 4])))
         else $error("FAIL req_hold[%0d]: request withdrawn before accept", i);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // scoreboard monitor: compares each transferred response with the queue head
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got id=%0d y=0x%0h expected no response", rsp_id, rsp_y);
         end else begin
            check("rsp", {rsp_id, rsp_y}, exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic wait_grant(input int id, output int gcyc);
      gcyc = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            gcyc = cyc;
            break;
         end
      end
      if (gcyc < 0) begin
         n_checks++;
         $display("FAIL grant_timeout: requester %0d got no req_ready expected within 60 cycles", id);
      end
   endtask

   task automatic issue_req(input int id, input logic op, input logic [3:0] a, input logic [3:0] b,
                            input logic [EW-1:0] exp, output int gcyc);
      req_op[id]       = op;
      req_a[4*id +: 4] = a;
      req_b[4*id +: 4] = b;
      req_valid[id]    = 1'b1;
      exp_q.push_back(exp);
      wait_grant(id, gcyc);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d responses outstanding expected 0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int g, t;
      int gids[8];
      int gcycs[8];
      int gcnt[NUM_REQ];
      int ng;

      reset     = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outs", {rsp_valid, busy, alu_en, alu_op, alu_a, alu_b}, '0);
      check("reset_rsp", {rsp_id, rsp_y}, '0);
      check("reset_ready", req_ready, '0);
      @(posedge clk); #1;
      reset = 1'b0;

      // single add: 7+9 on requester 2
      issue_req(2, OP_ADD, 4'd7, 4'd9, {2'd2, 8'h10}, g);
      @(negedge clk);
      check("add_issue_en", alu_en, 1'b1);
      check("add_issue_ops", {alu_op, alu_a, alu_b}, {1'b0, 4'd7, 4'd9});
      @(negedge clk);
      check("add_wait", {alu_en, rsp_valid, busy}, 3'b001);
      @(negedge clk);
      check("add_rsp_valid", rsp_valid, 1'b1);
      check("add_latency", cyc - g, 3);
      drain();

      // sub wrap and max add on requester 0, then requester 3 sets pointer to 0
      issue_req(0, OP_SUB, 4'd3, 4'd5, {2'd0, 8'hFE}, g);
      drain();
      issue_req(0, OP_ADD, 4'd15, 4'd15, {2'd0, 8'h1E}, g);
      drain();
      issue_req(3, OP_SUB, 4'd2, 4'd9, {2'd3, 8'hF9}, g);
      drain();

      // round robin: all requesters valid; each drops after its second grant
      for (int i = 0; i < NUM_REQ; i++) begin
         req_op[i]       = OP_ADD;
         req_a[4*i +: 4] = 4'(i);
         req_b[4*i +: 4] = 4'(i + 1);
         gcnt[i]         = 0;
      end
      for (int k = 0; k < 8; k++) exp_q.push_back({2'(k % 4), 8'(2 * (k % 4) + 1)});
      req_valid = '1;
      ng = 0;
      for (int n = 0; n < 80 && ng < 8; n++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            t = -1;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) t = i;
            gids[ng]  = t;
            gcycs[ng] = cyc;
            ng++;
            gcnt[t]++;
            @(posedge clk); #1;
            if (gcnt[t] == 2) req_valid[t] = 1'b0;
         end
      end
      req_valid = '0;
      check("rr_grant_count", ng, 8);
      for (int k = 0; k < ng; k++) check("rr_order", gids[k], k % 4);
      for (int k = 1; k < 5 && k < ng; k++) check("rr_spacing", gcycs[k] - gcycs[k-1], 4);
      drain();

      // backpressure: requester 1 held in RESP while requester 2 waits
      rsp_ready        = 1'b0;
      req_op[2]        = OP_SUB;
      req_a[4*2 +: 4]  = 4'd1;
      req_b[4*2 +: 4]  = 4'd1;
      req_valid[2]     = 1'b1;
      issue_req(1, OP_ADD, 4'd4, 4'd5, {2'd1, 8'h09}, g);
      exp_q.push_back({2'd2, 8'h00});
      for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         check("bp_hold", {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'd1, 8'h09});
         check("bp_quiet", {req_ready, alu_en}, '0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_handshake_no_grant", {rsp_valid, req_ready}, {1'b1, 4'b0000});
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_next_grant", {rsp_valid, req_ready}, {1'b0, 4'b0100});
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      drain();

      // reset during WAIT drops the op; pointer returns to 0
      req_op[0]       = OP_ADD;
      req_a[4*0 +: 4] = 4'd1;
      req_b[4*0 +: 4] = 4'd2;
      req_valid[0]    = 1'b1;
      wait_grant(0, g);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      reset           = 1'b1;
      req_op[1]       = OP_SUB;
      req_a[4*1 +: 4] = 4'd8;
      req_b[4*1 +: 4] = 4'd3;
      req_op[3]       = OP_ADD;
      req_a[4*3 +: 4] = 4'd15;
      req_b[4*3 +: 4] = 4'd1;
      req_valid[1]    = 1'b1;
      req_valid[3]    = 1'b1;
      @(negedge clk);
      check("rst_cycle_ready", req_ready, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.push_back({2'd1, 8'h05});
      exp_q.push_back({2'd3, 8'h10});
      @(negedge clk);
      check("rst_after", {rsp_valid, busy, alu_en}, 3'b000);
      check("rst_first_grant", req_ready, 4'b0010);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_grant(3, g);
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      drain();

      // idle quiet
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("idle_quiet", {alu_en, busy, rsp_valid, req_ready}, '0);
      end

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Round-robin scheduler that shares one 4-bit add/sub ALU (en/op/a/b in, registered 8-bit y out, one-cycle latency) between NUM_REQ requesters.
- Accepts one request at a time over a valid/ready handshake and sequences the ALU enable.
- Captures the ALU result and returns it with the requester id over a valid/ready response channel.
- Sits between client blocks and the ALU instance; it is the only driver of the ALU's en/op/a/b.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  NUM_REQ  per-requester op (0 = add, 1 = sub).
- req_a  input  4*NUM_REQ  per-requester operand a; requester i on bits [4i+3:4i].
- req_b  input  4*NUM_REQ  per-requester operand b; same packing as req_a.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_y  output  8  result.
- busy  output  1  high whenever the FSM is not in IDLE.
- alu_en  output  1  ALU enable.
- alu_op  output  1  ALU op.
- alu_a  output  4  ALU operand a.
- alu_b  output  4  ALU operand b.
- alu_y  input  8  ALU registered result.

Behaviour:
- Reset (sync, active-high), effective at the next rising edge:
  - state = IDLE; rr pointer = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_y = 0, busy = 0.
  - alu_en = 0, alu_op = 0, alu_a = 0, alu_b = 0.
  - req_ready = 0 during the reset cycle.
  - An in-flight operation is dropped silently with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant winner w by round robin: search starts at pointer, wraps modulo NUM_REQ.
  - req_ready[w] = 1 combinationally in this cycle only.
  - At the edge, latch op/a/b/w into internal registers and go to ISSUE.
  - Otherwise stay in IDLE with req_ready = 0.
- ISSUE: alu_en = 1 for exactly one cycle with the latched op/a/b on alu_op/alu_a/alu_b. The ALU updates y at the end of this cycle. Go to WAIT.
- WAIT:
  - alu_en = 0; alu_y is valid.
  - At the edge, register rsp_y <= alu_y and rsp_id <= w.
  - Set pointer <= (w+1) mod NUM_REQ and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_y are held stable until rsp_ready is sampled high.
  - On rsp_valid & rsp_ready at an edge, go to IDLE with rsp_valid = 0 from the next cycle.
  - No new grant is made in the handshake cycle.
- Latency and throughput:
  - Accept in cycle T, alu_en in T+1, rsp_valid first high in T+3.
  - Best-case throughput is one operation per 4 cycles.
- alu_en is never high outside ISSUE.
- alu_op/alu_a/alu_b hold their last latched values outside ISSUE, to reduce toggling.
- Arithmetic:
  - The scheduler does not modify alu_y.
  - The ALU computes in 8 bits, so sub wraps modulo 256 (3-5 = 0xFE).
  - The maximum add result is 15+15 = 0x1E.
- The scheduler never relies on the ALU's own reset value, because every response comes from a fresh ISSUE.
- Requester protocol: req_valid must stay high with stable operands until req_ready. Behaviour on early withdrawal is undefined; the bench checks it with an assertion.
- Starvation: the pointer advances past each winner, so a continuously asserted requester is served within NUM_REQ grants.
- Simultaneous events:
  - Multiple req_valid: only one grant, per the rr pointer.
  - A req_valid that rises during ISSUE/WAIT/RESP waits for IDLE.
  - reset asserted in any state overrides all other behaviour.

Decomposition:
- Package alu_sched_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - Localparam RESULT_W = 8.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Combinational winner and any-valid, computed from req_valid and pointer.
  - Instantiated once; the pointer register lives in alu_sched.

Test Plan:
- Single add: req 2 valid, op=0, a=7, b=9 -> req_ready[2] in cycle T, alu_en only in T+1, rsp_valid in T+3 with rsp_id=2, rsp_y=0x10.
- Sub wrap: req 0 op=1, a=3, b=5 -> rsp_y=0xFE, rsp_id=0; then a=15, b=15 add -> rsp_y=0x1E.
- Round robin: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each grant 4 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id, rsp_y stable; req_ready=0 throughout; alu_en=0; next grant in the cycle after the handshake cycle.
- Reset mid-op: reset asserted in WAIT -> next cycle rsp_valid=0, busy=0, alu_en=0, no response for the dropped op; with reqs 1 and 3 pending, first grant goes to 1 (pointer 0).
- Idle quiet: no req_valid for 20 cycles -> alu_en=0, busy=0, rsp_valid=0, state stays IDLE.
